// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE -> ISSUE -> RESP per operation.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter logic [4:0] IDLE_OP = 5'd0
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [4:0] req0_op,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [4:0] req1_op,

    output logic       resp0_valid,
    input  logic       resp0_ready,
    output logic [7:0] resp0_result,
    output logic       resp0_shift_ovf,
    output logic       resp0_arith_ovf,

    output logic       resp1_valid,
    input  logic       resp1_ready,
    output logic [7:0] resp1_result,
    output logic       resp1_shift_ovf,
    output logic       resp1_arith_ovf,

    output logic [7:0] alu_operand_a,
    output logic [7:0] alu_operand_b,
    output logic [4:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_shift_overflow,
    input  logic       alu_arithmetic_overflow,

    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic       grant;
    logic       grant_idx;
    logic       accept;
    logic       resp_fire;
    logic       resp_valid;
    logic [7:0] cap_result;
    logic       cap_shift_ovf;
    logic       cap_arith_ovf;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic       last_grant;
`endif

    // Grant is only meaningful while some request is valid; a lone requester always wins.
    always_comb begin
        grant = req1_valid & ~req0_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end
    end

    assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign resp_fire  = (state == RESP) && (grant_idx ? resp1_ready : resp0_ready);

    assign resp0_valid     = resp_valid && !grant_idx;
    assign resp1_valid     = resp_valid && grant_idx;
    assign resp0_result    = cap_result;
    assign resp1_result    = cap_result;
    assign resp0_shift_ovf = cap_shift_ovf;
    assign resp1_shift_ovf = cap_shift_ovf;
    assign resp0_arith_ovf = cap_arith_ovf;
    assign resp1_arith_ovf = cap_arith_ovf;

    // ALU drive registers double as the latched payload: loaded on accept, cleared leaving ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            grant_idx     <= 1'b0;
            resp_valid    <= 1'b0;
            cap_result    <= 8'd0;
            cap_shift_ovf <= 1'b0;
            cap_arith_ovf <= 1'b0;
            alu_operand_a <= 8'd0;
            alu_operand_b <= 8'd0;
            alu_op        <= IDLE_OP;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= ISSUE;
                        busy          <= 1'b1;
                        grant_idx     <= grant;
                        alu_operand_a <= grant ? req1_a  : req0_a;
                        alu_operand_b <= grant ? req1_b  : req0_b;
                        alu_op        <= grant ? req1_op : req0_op;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_grant    <= grant;
`endif
                    end
                end
                ISSUE: begin
                    state         <= RESP;
                    resp_valid    <= 1'b1;
                    cap_result    <= alu_result;
                    cap_shift_ovf <= alu_shift_overflow;
                    cap_arith_ovf <= alu_arithmetic_overflow;
                    alu_operand_a <= 8'd0;
                    alu_operand_b <= 8'd0;
                    alu_op        <= IDLE_OP;
                end
                RESP: begin
                    if (resp_fire) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
